// File: rtl/sb_loopback_pkg.sv
// sb_loopback_pkg: shared types and helpers for the switchboard byte-increment
// loopback initiator.
//   sb_lb_state_e  : run-level FSM states
//   SB_LB_NO_ERR   : first_err_idx value meaning "no error seen"
//   sb_lb_pattern  : packet pattern generator; byte i = idx[7:0] + i + offset
package sb_loopback_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TERM = 2'd2,
    DONE = 2'd3
  } sb_lb_state_e;

  localparam logic [15:0] SB_LB_NO_ERR = 16'hFFFF;

  // Widest stream the pattern helper can build; callers size-cast the result
  // down to their own DW.
  localparam int SB_LB_MAX_DW = 1024;

  // offset=0 gives the transmitted pattern, offset=1 the expected response.
  // Adjacent lanes always differ, so a test packet can never be all-ones.
  function automatic logic [SB_LB_MAX_DW-1:0] sb_lb_pattern(
    input logic [15:0] idx,
    input logic [7:0]  offset,
    input int          dw
  );
    logic [SB_LB_MAX_DW-1:0] p;
    p = '0;
    for (int i = 0; i < SB_LB_MAX_DW / 8; i++) begin
      if (i < dw / 8) p[i*8 +: 8] = idx[7:0] + 8'(i) + offset;
    end
    return p;
  endfunction

endpackage

// File: rtl/sb_lb_checker.sv
// sb_lb_checker: response checker for the loopback initiator.
//   rx_hs       : a response beat is being accepted this cycle
//   expect_vld  : a sent packet is outstanding (otherwise the beat is spurious)
//   rx_idx      : index of the packet the beat should answer
//   exp_data    : expected response data for rx_idx
//   rx_data/rx_dest/rx_last : the returned beat
//   err_count   : saturating error count
//   first_err_idx : rx_idx at the first error, SB_LB_NO_ERR if none
module sb_lb_checker
  import sb_loopback_pkg::*;
#(
  parameter int          DW   = 256,
  parameter logic [31:0] DEST = 32'd0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_hs,
  input  logic          expect_vld,
  input  logic [15:0]   rx_idx,
  input  logic [DW-1:0] exp_data,
  input  logic [DW-1:0] rx_data,
  input  logic [31:0]   rx_dest,
  input  logic          rx_last,
  output logic [15:0]   err_count,
  output logic [15:0]   first_err_idx
);

  logic        miss, err;
  logic [15:0] err_count_q, err_count_d;
  logic [15:0] first_err_idx_q, first_err_idx_d;

  // A beat with nothing outstanding is an error regardless of its contents.
  assign miss = !expect_vld || (rx_data != exp_data) || (rx_dest != DEST) || !rx_last;
  assign err  = rx_hs && miss;

  always_comb begin
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;
    if (err) begin
      if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
      if (first_err_idx_q == SB_LB_NO_ERR) first_err_idx_d = rx_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q     <= 16'd0;
      first_err_idx_q <= SB_LB_NO_ERR;
    end else begin
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;
    end
  end

  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;

endmodule

// File: rtl/sb_loopback_initiator.sv
// sb_loopback_initiator: initiator end of the switchboard byte-increment
// loopback. Sends NUM_PKTS numbered single-beat packets on the TX stream,
// checks each response for every byte = sent byte + 1, then sends one
// all-ones terminate packet.
//   clk, rst (sync, active high), start (one-cycle pulse from IDLE)
//   tx_*    : outgoing SB stream (tx_dest = DEST, tx_last = tx_valid)
//   rx_*    : returned SB stream, always drained once a run has started
//   busy    : RUN or TERM;  done : terminate accepted (sticky)
//   pass    : done with no errors;  err_count / first_err_idx : checker results
module sb_loopback_initiator
  import sb_loopback_pkg::*;
#(
  parameter int          DW              = 256,
  parameter int          NUM_PKTS        = 16,
  parameter logic [31:0] DEST            = 32'd0,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [DW-1:0] tx_data,
  output logic [31:0]   tx_dest,
  output logic          tx_last,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [DW-1:0] rx_data,
  input  logic [31:0]   rx_dest,
  input  logic          rx_last,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_count,
  output logic [15:0]   first_err_idx
);

  localparam logic [15:0] NUM_PKTS_W = 16'(NUM_PKTS);
  localparam logic [7:0]  MAX_OUT_W  = 8'(MAX_OUTSTANDING);

  sb_lb_state_e  state_q, state_d;
  logic [15:0]   tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
  logic [7:0]    outstanding_q, outstanding_d;
  logic          tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
  logic [DW-1:0] tx_data_q, tx_data_d;
  logic          rx_ready_q, rx_ready_d, busy_q, busy_d, done_q, done_d;
  logic          tx_hs, rx_hs, rx_expect, rx_take;
  logic [DW-1:0] rx_exp_data;

  assign tx_hs       = tx_valid_q && tx_ready;
  assign rx_hs       = rx_valid && rx_ready_q;
  assign rx_expect   = (outstanding_q != 8'd0);
  assign rx_take     = rx_hs && rx_expect;
  assign rx_exp_data = DW'(sb_lb_pattern(rx_idx_q, 8'd1, DW));

  always_comb begin
    state_d       = state_q;
    tx_idx_d      = tx_idx_q;
    rx_idx_d      = rx_idx_q;
    outstanding_d = outstanding_q;
    tx_valid_d    = tx_valid_q && !tx_hs;  // hold until accepted
    tx_data_d     = tx_data_q;
    done_d        = done_q;

    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (tx_hs)   tx_idx_d = tx_idx_q + 16'd1;
        if (rx_take) rx_idx_d = rx_idx_q + 16'd1;
        // simultaneous send and check leaves outstanding unchanged
        case ({tx_hs, rx_take})
          2'b10:   outstanding_d = outstanding_q + 8'd1;
          2'b01:   outstanding_d = outstanding_q - 8'd1;
          default: outstanding_d = outstanding_q;
        endcase
        if (tx_idx_d == NUM_PKTS_W && rx_idx_d == NUM_PKTS_W) state_d = TERM;
      end
      TERM: if (tx_hs) begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      default: ;  // DONE holds until reset
    endcase

    // Present the next beat as soon as the slot frees, using post-update
    // counters so back-to-back sends run at full rate.
    if (!tx_valid_d) begin
      if (state_d == RUN && tx_idx_d < NUM_PKTS_W && outstanding_d < MAX_OUT_W) begin
        tx_valid_d = 1'b1;
        tx_data_d  = DW'(sb_lb_pattern(tx_idx_d, 8'd0, DW));
      end else if (state_d == TERM) begin
        tx_valid_d = 1'b1;
        tx_data_d  = '1;
      end
    end

    tx_last_d  = tx_valid_d;
    rx_ready_d = (state_d != IDLE);
    busy_d     = (state_d == RUN) || (state_d == TERM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      tx_idx_q      <= 16'd0;
      rx_idx_q      <= 16'd0;
      outstanding_q <= 8'd0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      tx_last_q     <= 1'b0;
      rx_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_idx_q      <= tx_idx_d;
      rx_idx_q      <= rx_idx_d;
      outstanding_q <= outstanding_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      tx_last_q     <= tx_last_d;
      rx_ready_q    <= rx_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  sb_lb_checker #(.DW(DW), .DEST(DEST)) u_checker (
    .clk          (clk),
    .rst          (rst),
    .rx_hs        (rx_hs),
    .expect_vld   (rx_expect),
    .rx_idx       (rx_idx_q),
    .exp_data     (rx_exp_data),
    .rx_data      (rx_data),
    .rx_dest      (rx_dest),
    .rx_last      (rx_last),
    .err_count    (err_count),
    .first_err_idx(first_err_idx)
  );

  assign tx_data  = tx_data_q;
  assign tx_dest  = DEST;
  assign tx_last  = tx_last_q;
  assign tx_valid = tx_valid_q;
  assign rx_ready = rx_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = done_q && (err_count == 16'd0);

endmodule

// File: tb/tb_sb_loopback_initiator.sv
// Bench for sb_loopback_initiator: a +1 loopback responder with knobs for
// response delay, tx_ready stalls, response corruption and injected extra
// responses; sent packets are scoreboarded against expected patterns.
module tb_sb_loopback_initiator;

  localparam int          DW  = 64;
  localparam int          NP  = 4;
  localparam int          MO  = 2;
  localparam logic [31:0] DST = 32'h0000_00A5;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [DW-1:0] tx_data, rx_data = '0;
  logic [31:0]   tx_dest, rx_dest = DST;
  logic          tx_last, tx_valid, tx_ready = 1'b1;
  logic          rx_last = 1'b1, rx_valid = 1'b0, rx_ready;
  logic          busy, done, pass;
  logic [15:0]   err_count, first_err_idx;

  sb_loopback_initiator #(.DW(DW), .NUM_PKTS(NP), .DEST(DST), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .tx_data(tx_data), .tx_dest(tx_dest), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_dest(rx_dest), .rx_last(rx_last), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] data; int due; } resp_t;
  resp_t          resp_q[$];
  logic [DW+32:0] tx_obs[$], exp_q[$];   // {last, dest, data}
  logic [DW:0]    stall_obs[$];          // {valid, data}
  int   cyc = 0, tx_cnt = 0, stall_idx = -1, stall_left = 0, corrupt_idx = -1, resp_delay = 0;
  bit   stall_on = 0, inject_req = 0, rx_rdy_seen = 0;
  int   vectors = 0, miscompares = 0;

  function automatic logic [DW-1:0] pat(int k);
    logic [DW-1:0] p;
    for (int i = 0; i < DW / 8; i++) p[i*8 +: 8] = 8'((k + i) % 256);
    return p;
  endfunction

  function automatic logic [DW-1:0] plus1(logic [DW-1:0] d);
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 8; i++) r[i*8 +: 8] = d[i*8 +: 8] + 8'd1;
    return r;
  endfunction

  // Responder/monitor: decides tx_ready and rx beats at the falling edge, so
  // what it records is exactly what the DUT sees at the next rising edge.
  always @(negedge clk) begin
    resp_t r;
    cyc++;
    if (rst) begin
      resp_q.delete(); tx_obs.delete(); stall_obs.delete();
      tx_cnt = 0; stall_on = 0; inject_req = 0;
      rx_valid = 1'b0; tx_ready = 1'b1; rx_rdy_seen = 0;
    end else begin
      if (rx_valid && rx_rdy_seen) resp_q.delete(0);
      tx_ready = 1'b1;
      if (tx_cnt == stall_idx && stall_left > 0 && (tx_valid || stall_on)) begin
        tx_ready = 1'b0; stall_on = 1; stall_left--;
        stall_obs.push_back({tx_valid, tx_data});
      end
      if (tx_valid && tx_ready) begin
        tx_obs.push_back({tx_last, tx_dest, tx_data});
        if (tx_data !== '1) begin
          r.data = plus1(tx_data);
          if (tx_cnt == corrupt_idx) r.data[31:24] = r.data[31:24] ^ 8'h5A;
          r.due = cyc + 1 + resp_delay;
          resp_q.push_back(r);
        end
        tx_cnt++;
      end
      if (inject_req) begin
        r.data = pat(9); r.due = cyc + 1; resp_q.push_back(r); inject_req = 0;
      end
      if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
        rx_valid = 1'b1; rx_data = resp_q[0].data;
      end else rx_valid = 1'b0;
      rx_rdy_seen = rx_ready;
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic do_reset();
    rst = 1'b1; stall_idx = -1; stall_left = 0; corrupt_idx = -1; resp_delay = 0;
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic launch();
    for (int k = 0; k < NP; k++) exp_q.push_back({1'b1, DST, pat(k)});
    exp_q.push_back({1'b1, DST, {DW{1'b1}}});
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (done) ok = 1; else tick();
    end
  endtask

  task automatic wait_sent(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (tx_cnt == n) ok = 1; else tick();
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    vectors++;
    if ({tx_valid, tx_last, rx_ready, busy, done, pass} !== 6'b0) begin
      miscompares++; $display("FAIL reset_flags got %b want 000000", {tx_valid, tx_last, rx_ready, busy, done, pass});
    end
    vectors++;
    if (tx_data !== '0) begin miscompares++; $display("FAIL reset_tx_data got %h want 0", tx_data); end
    vectors++;
    if (err_count !== 16'd0) begin miscompares++; $display("FAIL reset_err_count got %h want 0", err_count); end
    vectors++;
    if (first_err_idx !== 16'hFFFF) begin miscompares++; $display("FAIL reset_first_err got %h want ffff", first_err_idx); end
  endtask

  task automatic test_basic();
    bit ok;
    logic [DW+32:0] e, o;
    do_reset();
    launch();
    vectors++;
    if (tx_valid !== 1'b1 || tx_data !== pat(0)) begin
      miscompares++; $display("FAIL basic_first_tx got v=%b %h want v=1 %h", tx_valid, tx_data, pat(0));
    end
    wait_done(300, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL basic_timeout got done=%b want 1", done); end
    tick();
    vectors++;
    if (tx_obs.size() != exp_q.size()) begin
      miscompares++; $display("FAIL basic_tx_count got %0d want %0d", tx_obs.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && tx_obs.size() > 0) begin
      e = exp_q.pop_front(); o = tx_obs.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL basic_tx_pkt got %h want %h", o, e); end
    end
    vectors++;
    if ({done, pass, busy, tx_valid, err_count, first_err_idx} !== {4'b1100, 16'd0, 16'hFFFF}) begin
      miscompares++; $display("FAIL basic_result got d=%b p=%b b=%b v=%b e=%h f=%h want d=1 p=1 b=0 v=0 e=0 f=ffff",
                              done, pass, busy, tx_valid, err_count, first_err_idx);
    end
  endtask

  task automatic test_tx_stall();
    bit ok;
    logic [DW:0] s;
    do_reset();
    stall_idx = 1; stall_left = 10;
    launch();
    wait_done(300, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL stall_timeout got done=%b want 1", done); end
    vectors++;
    if (stall_obs.size() != 10) begin miscompares++; $display("FAIL stall_len got %0d want 10", stall_obs.size()); end
    while (stall_obs.size() > 0) begin
      s = stall_obs.pop_front(); vectors++;
      if (s !== {1'b1, pat(1)}) begin miscompares++; $display("FAIL stall_hold got %h want %h", s, {1'b1, pat(1)}); end
    end
    vectors++;
    if (pass !== 1'b1 || err_count !== 16'd0) begin
      miscompares++; $display("FAIL stall_pass got p=%b e=%h want p=1 e=0", pass, err_count);
    end
  endtask

  task automatic test_corrupt();
    bit ok;
    do_reset();
    corrupt_idx = 2;
    launch();
    wait_done(300, ok);
    tick();
    vectors++;
    if (!ok || {done, pass, err_count, first_err_idx} !== {2'b10, 16'd1, 16'd2}) begin
      miscompares++; $display("FAIL corrupt_result got ok=%b d=%b p=%b e=%h f=%h want ok=1 d=1 p=0 e=1 f=2",
                              ok, done, pass, err_count, first_err_idx);
    end
  endtask

  task automatic test_outstanding();
    bit ok;
    do_reset();
    resp_delay = 20;
    launch();
    wait_sent(2, 50, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL outst_sent got %0d want 2", tx_cnt); end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL outst_block got v=%b want 0 (cycle %0d)", tx_valid, i); end
      tick();
    end
    vectors++;
    if (tx_cnt != 2) begin miscompares++; $display("FAIL outst_count got %0d want 2", tx_cnt); end
    wait_done(500, ok);
    tick();
    vectors++;
    if (!ok || pass !== 1'b1) begin miscompares++; $display("FAIL outst_pass got ok=%b p=%b want 1 1", ok, pass); end
  endtask

  task automatic test_reset_midrun();
    bit ok;
    logic [DW+32:0] e, o;
    do_reset();
    resp_delay = 5;
    launch();
    wait_sent(2, 50, ok);
    rst = 1'b1;
    tick();
    vectors++;
    if (!ok || {tx_valid, tx_last, rx_ready, busy, done, pass} !== 6'b0) begin
      miscompares++; $display("FAIL midrst_flags got ok=%b %b want ok=1 000000", ok, {tx_valid, tx_last, rx_ready, busy, done, pass});
    end
    vectors++;
    if (tx_data !== '0 || err_count !== 16'd0 || first_err_idx !== 16'hFFFF) begin
      miscompares++; $display("FAIL midrst_data got d=%h e=%h f=%h want 0 0 ffff", tx_data, err_count, first_err_idx);
    end
    rst = 1'b0;
    exp_q.delete();
    tick();
    launch();
    wait_done(400, ok);
    tick();
    vectors++;
    if (!ok || pass !== 1'b1) begin miscompares++; $display("FAIL midrst_pass got ok=%b p=%b want 1 1", ok, pass); end
    vectors++;
    if (tx_obs.size() != exp_q.size()) begin
      miscompares++; $display("FAIL midrst_tx_count got %0d want %0d", tx_obs.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && tx_obs.size() > 0) begin
      e = exp_q.pop_front(); o = tx_obs.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL midrst_tx_pkt got %h want %h", o, e); end
    end
  endtask

  task automatic test_spurious();
    bit ok;
    do_reset();
    launch();
    wait_done(300, ok);
    inject_req = 1;
    repeat (6) tick();
    vectors++;
    if (!ok || {done, pass, err_count, first_err_idx} !== {2'b10, 16'd1, 16'd4}) begin
      miscompares++; $display("FAIL spurious_result got ok=%b d=%b p=%b e=%h f=%h want ok=1 d=1 p=0 e=1 f=4",
                              ok, done, pass, err_count, first_err_idx);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tx_stall();
    test_corrupt();
    test_outstanding();
    test_reset_midrun();
    test_spurious();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
